// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and default timing constants for the SDRAM request arbiter.
package sdram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRefresh
    } arb_state_t;

    // 7.8 us refresh period at 133 MHz
    localparam int unsigned RefIntervalDefault = 1040;
    localparam int unsigned TimeoutDefault     = 512;

endpackage

// File: rtl/sdram_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module sdram_req_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ_p = 4,
    localparam int unsigned IdW = $clog2(NUM_REQ_p)
) (
    input  logic [NUM_REQ_p-1:0] req,
    input  logic [IdW-1:0]       ptr,
    output logic [NUM_REQ_p-1:0] grant,
    output logic [IdW-1:0]       idx,
    output logic                 any_req
);

    logic found;

    assign any_req = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ_p; k++) begin
            int unsigned cand;
            cand = (32'(ptr) + k) % NUM_REQ_p;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IdW'(cand);
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM command sequencer among requesters and
// a periodic refresh scheduler, with a watchdog on hung sequencer operations.
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ_p      = 4,
    parameter int unsigned REF_INTERVAL_p = RefIntervalDefault,
    parameter int unsigned TIMEOUT_p      = TimeoutDefault,
    parameter int unsigned ADDR_W_p       = 24,
    localparam int unsigned IdW = $clog2(NUM_REQ_p)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ_p-1:0]          req_valid_i,
    input  logic [NUM_REQ_p-1:0]          req_we_i,
    input  logic [NUM_REQ_p*ADDR_W_p-1:0] req_addr_i,
    output logic [NUM_REQ_p-1:0]          req_ready_o,
    output logic                          seq_go_o,
    output logic                          seq_rw_en_o,
    output logic [ADDR_W_p-1:0]           seq_addr_o,
    output logic                          seq_refresh_o,
    input  logic                          seq_done_i,
    output logic [IdW-1:0]                grant_id_o,
    output logic                          busy_o,
    output logic                          error_o
);

    localparam int unsigned RefW = $clog2(REF_INTERVAL_p);
    localparam int unsigned WdW  = $clog2(TIMEOUT_p);

    arb_state_t          state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [IdW-1:0]      grant_id_q, grant_id_d;
    logic [ADDR_W_p-1:0] addr_q, addr_d;
    logic [RefW-1:0]     ref_cnt_q;
    logic                ref_pending_q;
    logic                ref_clear;
    logic [WdW-1:0]      wdog_q, wdog_d;
    logic                error_q, error_d;

    logic [NUM_REQ_p-1:0] rr_grant;
    logic [IdW-1:0]       rr_idx;
    logic                 rr_any;

    sdram_req_arbiter_rr_arbiter #(
        .NUM_REQ_p(NUM_REQ_p)
    ) u_rr (
        .req    (req_valid_i),
        .ptr    (ptr_q),
        .grant  (rr_grant),
        .idx    (rr_idx),
        .any_req(rr_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        addr_d        = addr_q;
        error_d       = error_q;
        wdog_d        = wdog_q + WdW'(1);
        ref_clear     = 1'b0;
        req_ready_o   = '0;
        seq_go_o      = 1'b0;
        seq_rw_en_o   = 1'b0;
        seq_refresh_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                wdog_d = '0;
                // Launches are suppressed while reset is held so outputs stay quiet.
                if (!rst_i && ref_pending_q) begin
                    seq_refresh_o = 1'b1;
                    ref_clear     = 1'b1;
                    state_d       = StRefresh;
                end else if (!rst_i && rr_any) begin
                    req_ready_o = rr_grant;
                    seq_go_o    = 1'b1;
                    seq_rw_en_o = req_we_i[rr_idx];
                    addr_d      = req_addr_i[rr_idx*ADDR_W_p +: ADDR_W_p];
                    grant_id_d  = rr_idx;
                    ptr_d       = (rr_idx == IdW'(NUM_REQ_p - 1)) ? '0 : rr_idx + IdW'(1);
                    state_d     = StBusy;
                end
            end
            StBusy, StRefresh: begin
                if (seq_done_i) begin
                    state_d = StIdle;
                end else if (wdog_q == WdW'(TIMEOUT_p - 1)) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            addr_q        <= '0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            wdog_q        <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            addr_q     <= addr_d;
            wdog_q     <= wdog_d;
            error_q    <= error_d;
            // A wrap sets pending even if IDLE consumes it in the same cycle.
            if (ref_cnt_q == RefW'(REF_INTERVAL_p - 1)) begin
                ref_cnt_q     <= '0;
                ref_pending_q <= 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q + RefW'(1);
                if (ref_clear) begin
                    ref_pending_q <= 1'b0;
                end
            end
        end
    end

    assign seq_addr_o = addr_q;
    assign grant_id_o = grant_id_q;
    assign busy_o     = (state_q != StIdle);
    assign error_o    = error_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: two instances (short watchdog / short refresh period)
// driven by a shared stimulus set, checked against a scoreboard of expected launches.
module tb_sdram_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 24;

    typedef struct {
        int            ev;
        logic          we;
        logic [AW-1:0] addr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic            seq_done;

    logic [N-1:0]  ready_a, ready_b;
    logic          go_a, go_b, rw_a, rw_b, refresh_a, refresh_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [1:0]    gid_a, gid_b;
    logic          busy_a, busy_b, err_a, err_b;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    sdram_req_arbiter #(
        .NUM_REQ_p(N), .REF_INTERVAL_p(1040), .TIMEOUT_p(16), .ADDR_W_p(AW)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_ready_o(ready_a), .seq_go_o(go_a),
        .seq_rw_en_o(rw_a), .seq_addr_o(addr_a), .seq_refresh_o(refresh_a),
        .seq_done_i(seq_done), .grant_id_o(gid_a), .busy_o(busy_a), .error_o(err_a)
    );

    sdram_req_arbiter #(
        .NUM_REQ_p(N), .REF_INTERVAL_p(20), .TIMEOUT_p(512), .ADDR_W_p(AW)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_ready_o(ready_b), .seq_go_o(go_b),
        .seq_rw_en_o(rw_b), .seq_addr_o(addr_b), .seq_refresh_o(refresh_b),
        .seq_done_i(seq_done), .grant_id_o(gid_b), .busy_o(busy_b), .error_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return 9;
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return 9;
    endfunction

    // Leaves the caller at the negedge of the first active cycle (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; seq_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Samples each cycle for a launch; ev = grant index, 8 = refresh, -1 = none in bound.
    task automatic wait_launch(input bit use_b, input int bound, output int ev, output int waited);
        ev = -1;
        waited = bound;
        for (int c = 0; c < bound; c++) begin
            #1;
            if (use_b ? refresh_b : refresh_a) begin
                ev = 8; waited = c; return;
            end
            if (use_b ? go_b : go_a) begin
                ev = onehot_idx(use_b ? ready_b : ready_a); waited = c; return;
            end
            @(negedge clk);
            seq_done = 1'b0;
        end
    endtask

    // Pulses done lat cycles after the current one and returns at the next cycle's negedge.
    task automatic hold_then_done(input int lat);
        repeat (lat) @(negedge clk);
        seq_done = 1'b1;
        @(negedge clk);
        seq_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (ready_a !== 4'b0) $display("FAIL reset_ready: got %b want 0000", ready_a); else n_pass++;
        n_checks++; if (go_a !== 1'b0) $display("FAIL reset_go: got %b want 0", go_a); else n_pass++;
        n_checks++; if (refresh_a !== 1'b0) $display("FAIL reset_refresh: got %b want 0", refresh_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL reset_error: got %b want 0", err_a); else n_pass++;
        n_checks++; if (addr_a !== 24'h0) $display("FAIL reset_addr: got %h want 000000", addr_a); else n_pass++;
        n_checks++; if (gid_a !== 2'd0) $display("FAIL reset_gid: got %0d want 0", gid_a); else n_pass++;
    endtask

    task automatic test_single_grant();
        do_reset();
        req_valid = 4'b0100; req_we = 4'b0100; req_addr[2*AW +: AW] = 24'h001234;
        #1;
        n_checks++; if (ready_a !== 4'b0100) $display("FAIL single_ready: got %b want 0100", ready_a); else n_pass++;
        n_checks++; if (go_a !== 1'b1) $display("FAIL single_go: got %b want 1", go_a); else n_pass++;
        n_checks++; if (rw_a !== 1'b1) $display("FAIL single_rw: got %b want 1", rw_a); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (addr_a !== 24'h001234) $display("FAIL single_addr: got %h want 001234", addr_a); else n_pass++;
        n_checks++; if (gid_a !== 2'd2) $display("FAIL single_gid: got %0d want 2", gid_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL single_busy: got %b want 1", busy_a); else n_pass++;
        n_checks++; if (go_a !== 1'b0) $display("FAIL single_go_once: got %b want 0", go_a); else n_pass++;
        hold_then_done(2);
        #1;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL single_idle_after_done: got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_fairness();
        int   ev, waited;
        exp_t e;
        do_reset();
        req_valid = 4'b1111;
        req_we    = 4'b1010;
        for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = 24'h100000 + 24'(k * 'h111);
        for (int i = 0; i < 5; i++) begin
            e.ev = i % N; e.we = req_we[i % N]; e.addr = 24'h100000 + 24'((i % N) * 'h111);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_launch(1'b0, 20, ev, waited);
            n_checks++; if (ev !== e.ev) $display("FAIL rr_order: got %0d want %0d", ev, e.ev); else n_pass++;
            n_checks++; if (waited !== 0) $display("FAIL rr_go_gap: got %0d extra cycles want 0", waited); else n_pass++;
            n_checks++; if (rw_a !== e.we) $display("FAIL rr_rw: got %b want %b", rw_a, e.we); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (addr_a !== e.addr) $display("FAIL rr_addr: got %h want %h", addr_a, e.addr); else n_pass++;
            n_checks++; if (gid_a !== 2'(e.ev)) $display("FAIL rr_gid: got %0d want %0d", gid_a, e.ev); else n_pass++;
            hold_then_done(4);
        end
        req_valid = '0;
    endtask

    task automatic test_refresh_preempt();
        int   ev, waited;
        int   lat[4];
        exp_t e;
        lat = '{18, 2, 3, 2};
        do_reset();
        req_valid = 4'b0001; req_we = 4'b0000; req_addr[0 +: AW] = 24'h000abc;
        // Done at cycle 18 returns to IDLE at 19, before the wrap at 19 is visible.
        e.ev = 0; e.we = 1'b0; e.addr = 24'h000abc; sb.push_back(e);
        e.ev = 0; sb.push_back(e);
        e.ev = 8; sb.push_back(e);
        e.ev = 0; sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            wait_launch(1'b1, 40, ev, waited);
            n_checks++; if (ev !== e.ev) $display("FAIL ref_order[%0d]: got %0d want %0d", i, ev, e.ev); else n_pass++;
            n_checks++; if (waited !== 0) $display("FAIL ref_gap[%0d]: got %0d want 0", i, waited); else n_pass++;
            if (e.ev == 8) begin
                n_checks++; if (ready_b !== 4'b0) $display("FAIL ref_preempt_ready: got %b want 0000", ready_b); else n_pass++;
                n_checks++; if (go_b !== 1'b0) $display("FAIL ref_preempt_go: got %b want 0", go_b); else n_pass++;
            end
            hold_then_done(lat[i]);
        end
        req_valid = '0;
        #1;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL ref_final_idle: got %b want 0", busy_b); else n_pass++;
    endtask

    task automatic test_refresh_no_queue();
        int ev, waited;
        do_reset();
        req_valid = 4'b0001;
        wait_launch(1'b1, 5, ev, waited);
        n_checks++; if (ev !== 0) $display("FAIL nq_first_grant: got %0d want 0", ev); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        hold_then_done(59);
        wait_launch(1'b1, 5, ev, waited);
        n_checks++; if (ev !== 8) $display("FAIL nq_refresh: got %0d want 8", ev); else n_pass++;
        hold_then_done(2);
        wait_launch(1'b1, 12, ev, waited);
        n_checks++; if (ev !== -1) $display("FAIL nq_second_refresh: got %0d want none", ev); else n_pass++;
        wait_launch(1'b1, 30, ev, waited);
        n_checks++; if (ev !== 8) $display("FAIL nq_next_period: got %0d want 8", ev); else n_pass++;
        n_checks++; if (waited !== 4) $display("FAIL nq_period_phase: got %0d want 4", waited); else n_pass++;
    endtask

    task automatic test_timeout();
        int ev, waited;
        do_reset();
        req_valid = 4'b0010; req_we = 4'b0010; req_addr[1*AW +: AW] = 24'h000055;
        wait_launch(1'b0, 5, ev, waited);
        n_checks++; if (ev !== 1) $display("FAIL to_grant: got %0d want 1", ev); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        #1;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL to_busy_16th: got %b want 1", busy_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL to_early_error: got %b want 0", err_a); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (err_a !== 1'b1) $display("FAIL to_error: got %b want 1", err_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL to_idle: got %b want 0", busy_a); else n_pass++;
        @(negedge clk);
        req_valid = 4'b0100; req_we = 4'b0000;
        wait_launch(1'b0, 5, ev, waited);
        n_checks++; if (ev !== 2) $display("FAIL to_regrant: got %0d want 2", ev); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        hold_then_done(2);
        #1;
        n_checks++; if (err_a !== 1'b1) $display("FAIL to_sticky: got %b want 1", err_a); else n_pass++;
    endtask

    task automatic test_reset_in_busy();
        int ev, waited;
        do_reset();
        req_valid = 4'b0010; req_we = 4'b0010; req_addr[1*AW +: AW] = 24'h00beef;
        wait_launch(1'b0, 5, ev, waited);
        n_checks++; if (ev !== 1) $display("FAIL rb_grant: got %0d want 1", ev); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL rb_busy: got %b want 1", busy_a); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; seq_done = 1'b1;
        #1;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rb_busy_cleared: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (gid_a !== 2'd0) $display("FAIL rb_gid_cleared: got %0d want 0", gid_a); else n_pass++;
        n_checks++; if (addr_a !== 24'h0) $display("FAIL rb_addr_cleared: got %h want 000000", addr_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL rb_error_cleared: got %b want 0", err_a); else n_pass++;
        n_checks++; if (go_a !== 1'b0) $display("FAIL rb_go_quiet: got %b want 0", go_a); else n_pass++;
        @(negedge clk);
        seq_done = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rb_stale_done: got %b want 0", busy_a); else n_pass++;
        n_checks++; if (go_a !== 1'b0) $display("FAIL rb_spurious_go: got %b want 0", go_a); else n_pass++;
        @(negedge clk);
        req_valid = 4'b1111;
        wait_launch(1'b0, 5, ev, waited);
        n_checks++; if (ev !== 0) $display("FAIL rb_ptr_reset: got %0d want 0", ev); else n_pass++;
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; seq_done = 1'b0;
        test_reset();
        test_single_grant();
        test_fairness();
        test_refresh_preempt();
        test_refresh_no_queue();
        test_timeout();
        test_reset_in_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
